// File: rtl/key_event_pkg.sv
// Shared event codes, gesture FSM states and FIFO entry layout
// for the key event classifier.
package key_event_pkg;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        HELD     = 3'd2,
        WAIT2    = 3'd3,
        PRESSED2 = 3'd4
    } key_state_t;

    typedef struct packed {
        logic [1:0] key;
        logic [1:0] code;
    } evt_t;

endpackage

// File: rtl/key_gesture_fsm.sv
// Per-key gesture recogniser: edge detect, tick timer, SHORT/LONG/DOUBLE
// FSM and a one-entry pending slot drained by the top-level arbiter.
module key_gesture_fsm
    import key_event_pkg::*;
#(
    parameter int unsigned LONG_TICKS = 800,
    parameter int unsigned DBL_TICKS  = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_n,
    input  logic       clear,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       drop
);

    localparam int unsigned MAX_T = (LONG_TICKS > DBL_TICKS) ? LONG_TICKS : DBL_TICKS;
    localparam int unsigned TMR_W = $clog2(MAX_T + 1);
    localparam logic [TMR_W-1:0] LONG_T = TMR_W'(LONG_TICKS);
    localparam logic [TMR_W-1:0] DBL_T  = TMR_W'(DBL_TICKS);

    key_state_t       state, state_d;
    logic [TMR_W-1:0] timer;
    logic             prev;
    logic             prs_edge, rel_edge;
    logic             post;
    logic [1:0]       post_type;
    logic             slot_free;

    assign prs_edge = prev & ~key_n;
    assign rel_edge = ~prev & key_n;

    // Edges are tested before thresholds so an edge wins a same-cycle tie.
    always_comb begin
        state_d   = state;
        post      = 1'b0;
        post_type = EVT_NONE;
        case (state)
            IDLE: begin
                if (prs_edge) state_d = PRESSED;
            end
            PRESSED: begin
                if (rel_edge) begin
                    state_d = WAIT2;
                end else if (timer == LONG_T) begin
                    state_d   = HELD;
                    post      = 1'b1;
                    post_type = EVT_LONG;
                end
            end
            HELD: begin
                if (rel_edge) state_d = IDLE;
            end
            WAIT2: begin
                if (prs_edge) begin
                    state_d = PRESSED2;
                end else if (timer == DBL_T) begin
                    state_d   = IDLE;
                    post      = 1'b1;
                    post_type = EVT_SHORT;
                end
            end
            PRESSED2: begin
                if (rel_edge) begin
                    state_d   = IDLE;
                    post      = 1'b1;
                    post_type = EVT_DOUBLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A slot being drained this cycle can take a new post in the same cycle.
    assign slot_free = ~pend_valid | clear;
    assign drop      = post & ~slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= 1'b0;
            state      <= IDLE;
            timer      <= '0;
            pend_valid <= 1'b0;
            pend_type  <= EVT_NONE;
        end else begin
            prev  <= key_n;
            state <= state_d;
            if (state_d != state) begin
                timer <= '0;
            end else if (tick && (timer != '1)) begin
                timer <= timer + 1'b1;
            end
            if (post && slot_free) begin
                pend_valid <= 1'b1;
                pend_type  <= post_type;
            end else if (clear) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key presses into SHORT/LONG/DOUBLE events and
// queues them in a show-ahead FIFO with a valid/ready output.
module key_event_classifier
    import key_event_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 3,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned LONG_TICKS = 800,
    parameter int unsigned DBL_TICKS  = 250,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [1:0]          evt_key,
    output logic [1:0]          evt_type,
    output logic                overflow
);

    localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W = AW + 1;

    logic [PS_W-1:0]     ps_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] pend_valid;
    logic [1:0]          pend_type [NUM_KEYS];
    logic [NUM_KEYS-1:0] drop;
    logic [NUM_KEYS-1:0] clear;

    evt_t             mem [2**AW];
    evt_t             head;
    evt_t             push_evt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
    logic             full, push, pop, space;

    assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_gesture_fsm #(
            .LONG_TICKS (LONG_TICKS),
            .DBL_TICKS  (DBL_TICKS)
        ) u_key (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .key_n      (key_n[k]),
            .clear      (clear[k]),
            .pend_valid (pend_valid[k]),
            .pend_type  (pend_type[k]),
            .drop       (drop[k])
        );
    end

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PTR_W'(FIFO_DEPTH));
    assign evt_valid = (wr_ptr != rd_ptr);
    assign pop       = evt_valid & evt_ready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign space     = ~full | pop;

    always_comb begin
        clear    = '0;
        push     = 1'b0;
        push_evt = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (space && pend_valid[i] && !push) begin
                push          = 1'b1;
                clear[i]      = 1'b1;
                push_evt.key  = 2'(i);
                push_evt.code = pend_type[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_evt;
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign evt_key  = evt_valid ? head.key  : 2'b00;
    assign evt_type = evt_valid ? head.code : EVT_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_key_event_classifier.sv
// Scoreboard bench for key_event_classifier: directed gestures push expected
// events; a monitor pops and compares on every accepted output event.
module tb_key_event_classifier;
    import key_event_pkg::*;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q [$];

    key_event_classifier #(
        .NUM_KEYS   (3),
        .TICK_DIV   (TD),
        .LONG_TICKS (10),
        .DBL_TICKS  (5),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_type  (evt_type),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * TD) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual key=%0d type=%0d required none", evt_key, evt_type);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({evt_key, evt_type} !== e) begin
                    errors++;
                    $display("FAIL event actual key=%0d type=%0d required key=%0d type=%0d",
                             evt_key, evt_type, e[3:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", evt_valid, 0);
        check("rst_key", evt_key, 0);
        check("rst_type", evt_type, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ticks(2);

        // short press on key 0
        exp_q.push_back({2'd0, EVT_SHORT});
        key_n[0] = 1'b0;
        ticks(3);
        key_n[0] = 1'b1;
        ticks(4);
        check("short_not_early", exp_q.size(), 1);
        drain("short_drain", 200);
        ticks(3);

        // long press on key 1
        exp_q.push_back({2'd1, EVT_LONG});
        key_n[1] = 1'b0;
        ticks(9);
        check("long_not_early", exp_q.size(), 1);
        ticks(6);
        check("long_while_held", exp_q.size(), 0);
        key_n[1] = 1'b1;
        ticks(8);

        // double press on key 2, output two cycles after second release
        exp_q.push_back({2'd2, EVT_DOUBLE});
        key_n[2] = 1'b0; ticks(2);
        key_n[2] = 1'b1; ticks(2);
        key_n[2] = 1'b0; ticks(2);
        key_n[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("dbl_latency_pre", exp_q.size(), 1);
        @(posedge clk);
        #1 check("dbl_latency", exp_q.size(), 0);
        ticks(8);

        // simultaneous doubles on keys 0 and 1
        exp_q.push_back({2'd0, EVT_DOUBLE});
        exp_q.push_back({2'd1, EVT_DOUBLE});
        key_n[1:0] = 2'b00; ticks(2);
        key_n[1:0] = 2'b11; ticks(2);
        key_n[1:0] = 2'b00; ticks(2);
        key_n[1:0] = 2'b11;
        repeat (2) @(posedge clk);
        #1 check("simul_pre", exp_q.size(), 2);
        @(posedge clk);
        #1 check("simul_first", exp_q.size(), 1);
        @(posedge clk);
        #1 check("simul_second", exp_q.size(), 0);
        ticks(8);

        // backpressure: 4 in FIFO, 1 pending, 6th dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({2'd0, EVT_SHORT});
            key_n[0] = 1'b0; ticks(2);
            key_n[0] = 1'b1; ticks(7);
        end
        check("bp_no_overflow", overflow, 0);
        check("bp_valid", evt_valid, 1);
        key_n[0] = 1'b0; ticks(2);
        key_n[0] = 1'b1; ticks(7);
        check("bp_overflow", overflow, 1);
        evt_ready = 1'b1;
        drain("bp_drain", 100);
        check("bp_overflow_sticky", overflow, 1);
        ticks(3);

        // reset while key 0 is held mid-gesture
        key_n[0] = 1'b0;
        ticks(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", evt_valid, 0);
        check("midrst_key", evt_key, 0);
        check("midrst_type", evt_type, 0);
        check("midrst_overflow", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ticks(12);
        key_n[0] = 1'b1;
        ticks(8);
        check("midrst_silent", exp_q.size(), 0);
        exp_q.push_back({2'd0, EVT_SHORT});
        key_n[0] = 1'b0; ticks(2);
        key_n[0] = 1'b1;
        drain("midrst_new_press", 200);
        ticks(8);
        check("final_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
